// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell consumes operands LSB first, one bit per clock,
// and publishes {cout,sum} once the last bit has been processed.

module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] partial_next;
  logic             fa_s;
  logic             fa_c;

  FullAdder u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign partial_next = {fa_s, partial[WIDTH-1:1]};

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

  // Control and published result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt   <= '0;
            carry <= cin;
            state <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          carry <= fa_c;
          if (cnt == LAST) begin
            sum   <= partial_next;
            cout  <= fa_c;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand and partial-result shift registers; only meaningful while shifting
  always_ff @(posedge clk) begin
    if ((state != S_SHIFT) && start) begin
      sa <= a;
      sb <= b;
    end else if (state == S_SHIFT) begin
      sa      <= sa >> 1;
      sb      <= sb >> 1;
      partial <= partial_next;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed corner cases and random traffic at WIDTH=8,
// plus an exhaustive sweep at WIDTH=2.

module tb_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  int checks = 0;
  int errors = 0;
  int dones8 = 0;
  int dones2 = 0;
  int pushed8 = 0;
  int pushed2 = 0;
  logic [8:0] q8[$];
  logic [2:0] q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (done8) begin
      dones8++;
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL w8_unexpected_done actual={%0b,0x%0h} required=no_done", cout8, sum8);
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        chk("w8_result", {23'd0, cout8, sum8}, {23'd0, e});
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      dones2++;
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL w2_unexpected_done actual={%0b,%0d} required=no_done", cout2, sum2);
      end else begin
        logic [2:0] e;
        e = q2.pop_front();
        chk("w2_result", {29'd0, cout2, sum2}, {29'd0, e});
        if ({cout2, sum2} === e) $display("PASS w2 result=%0d", e);
      end
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input bit expect_done);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(posedge clk); #1;
    start8 = 1'b0;
    if (expect_done) begin
      q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
      pushed8++;
    end
  endtask

  task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic c);
    start2 = 1'b1; a2 = a; b2 = b; cin2 = c;
    @(posedge clk); #1;
    start2 = 1'b0;
    q2.push_back({1'b0, a} + {1'b0, b} + {2'd0, c});
    pushed2++;
  endtask

  // Counts sample points until done is seen; also counts cycles with busy high.
  task automatic wait_done8(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy8) bcnt++;
    end while (!done8 && lat < 100);
    if (!done8) begin
      checks++; errors++;
      $display("FAIL w8_timeout actual=no_done required=done_within_100");
    end
  endtask

  task automatic wait_done2(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done2 && lat < 100);
    if (!done2) begin
      checks++; errors++;
      $display("FAIL w2_timeout actual=no_done required=done_within_100");
    end
  endtask

  initial begin
    int lat, bc, d0, gap;
    logic [7:0] ra, rb;
    logic [7:0] held;

    // Reset with start asserted: reset must win.
    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    start2 = 1'b0; a2 = 2'd0; b2 = 2'd0; cin2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_sum", {24'd0, sum8}, 32'd0);
    chk("rst_cout", {31'd0, cout8}, 32'd0);
    start8 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy8}, 32'd0);

    // Zero operands: busy for 8 cycles, done in the 9th.
    @(posedge clk); #1;
    issue8(8'h00, 8'h00, 1'b0, 1'b1);
    wait_done8(lat, bc);
    chk("zero_lat", lat, 32'd9);
    chk("zero_busy_cycles", bc, 32'd8);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done8}, 32'd0);

    // Overflow cases.
    @(posedge clk); #1;
    issue8(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done8(lat, bc);
    @(posedge clk); #1;
    issue8(8'hFF, 8'hFF, 1'b1, 1'b1);
    wait_done8(lat, bc);
    chk("ovf_lat", lat, 32'd9);

    // Start during SHIFT is ignored.
    @(posedge clk); #1;
    d0 = dones8;
    issue8(8'h3C, 8'h0F, 1'b0, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(lat, bc);
    repeat (12) @(negedge clk);
    chk("ignored_start_done_count", dones8 - d0, 32'd1);
    chk("ignored_start_sum", {24'd0, sum8}, 32'h4B);

    // Reset in the middle of SHIFT aborts without a done pulse.
    @(posedge clk); #1;
    d0 = dones8;
    issue8(8'h80, 8'h80, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_sum", {24'd0, sum8}, 32'd0);
    chk("abort_cout", {31'd0, cout8}, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_no_done", dones8 - d0, 32'd0);

    // Back-to-back: new start during the done cycle; previous result held while shifting.
    @(posedge clk); #1;
    issue8(8'h12, 8'h34, 1'b0, 1'b1);
    wait_done8(lat, bc);
    held = 8'h46;
    issue8(8'h01, 8'h02, 1'b1, 1'b1);
    @(negedge clk);
    chk("b2b_busy", {31'd0, busy8}, 32'd1);
    chk("b2b_held_sum", {24'd0, sum8}, {24'd0, held});
    repeat (4) @(negedge clk);
    chk("b2b_held_mid", {24'd0, sum8}, {24'd0, held});
    wait_done8(lat, bc);
    chk("b2b_lat", 5 + lat, 32'd9);

    // Random traffic, mixing back-to-back and gapped starts.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      issue8(ra, rb, 1'($urandom), 1'b1);
      wait_done8(lat, bc);
      chk("rand_lat", lat, 32'd9);
    end

    // Exhaustive sweep at WIDTH=2.
    @(posedge clk); #1;
    for (int ai = 0; ai < 4; ai++)
      for (int bi = 0; bi < 4; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          issue2(2'(ai), 2'(bi), 1'(ci));
          wait_done2(lat);
          chk("w2_lat", lat, 32'd3);
          @(posedge clk); #1;
        end

    repeat (4) @(negedge clk);
    chk("w8_queue_empty", q8.size(), 32'd0);
    chk("w8_done_count", dones8, pushed8);
    chk("w2_queue_empty", q2.size(), 32'd0);
    chk("w2_done_count", dones2, pushed2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low, sampled on rising clk.
REQ-004 SHALL have port: start  input  1  request to begin an addition; sampled only while busy=0.
REQ-005 SHALL have port: a  input  WIDTH  first operand; sampled only on the accepted start edge.
REQ-006 SHALL have port: b  input  WIDTH  second operand; sampled only on the accepted start edge.
REQ-007 SHALL have port: cin  input  1  carry-in; sampled only on the accepted start edge.
REQ-008 SHALL have port: busy  output  1  high while bit-serial addition is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when sum/cout carry a new result.
REQ-010 SHALL have port: sum  output  WIDTH  registered result, a+b+cin mod 2^WIDTH.
REQ-011 SHALL have port: cout  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL accept start when state is IDLE or DONE (busy=0); accepting edge latches a, b into shift registers, cin into carry flop, clears bit counter, enters SHIFT.
REQ-014 SHALL ignore start while in SHIFT; operands, counter and carry unaffected.
REQ-015 SHALL, in SHIFT, process exactly one bit per clock, LSB first, using one instance of the team's FullAdder module: inputs current LSB of a, LSB of b, carry flop; sum bit shifted into partial result from MSB end, cout written to carry flop.
REQ-016 SHALL stay in SHIFT for exactly WIDTH cycles; bit counter wraps only via reload on next start, never free-runs.
REQ-017 SHALL, on the edge processing bit WIDTH-1, copy partial result to sum, final carry to cout, enter DONE.
REQ-018 SHALL assert done exactly for the one cycle the FSM is in DONE; DONE returns to IDLE next edge unless start=1, in which case it goes directly to SHIFT (back-to-back, no bubble).
REQ-019 SHALL drive busy=1 iff state is SHIFT; latency from accepting edge to done high is WIDTH+1 edges, busy high for WIDTH cycles.
REQ-020 SHALL hold sum and cout stable between done pulses, including during a following SHIFT; partial results never visible on sum.
REQ-021 SHALL produce sum/cout equal to {cout,sum} = a+b+cin for all operand values, including all-ones overflow.

Reset
REQ-022 SHALL, when rst_n=0 at a rising edge, force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry flop=0.
REQ-023 SHALL, on reset mid-SHIFT, abort the operation with no done pulse and no update of sum/cout beyond the reset values.
REQ-024 SHALL give reset priority over start on the same edge; start is accepted no earlier than the first edge with rst_n=1.

Verification
REQ-025 SHALL pass (WIDTH=8): start with a=0x00,b=0x00,cin=0 -> busy 8 cycles, done pulse 9th cycle, sum=0x00, cout=0.
REQ-026 SHALL pass: a=0xFF,b=0x01,cin=0 -> sum=0x00, cout=1; a=0xFF,b=0xFF,cin=1 -> sum=0xFF, cout=1.
REQ-027 SHALL pass: a=0x3C,b=0x0F,cin=0 started; start pulsed again with a=0xFF,b=0xFF at cycle 3 of SHIFT -> ignored, result sum=0x4B, cout=0, single done pulse.
REQ-028 SHALL pass: start a=0x80,b=0x80,cin=1; rst_n=0 at cycle 4 of SHIFT -> busy=0, done never asserted, sum=0x00, cout=0 next cycle.
REQ-029 SHALL pass: start asserted during done cycle with a=0x01,b=0x02,cin=1 -> no idle gap, busy next cycle, previous result held, new done 9 edges later with sum=0x04, cout=0.
REQ-030 SHALL pass (WIDTH=2): exhaustive sweep of all 32 (a,b,cin) combinations against {cout,sum}=a+b+cin, each reporting PASS.
